shift_add_multiplier_20x20: RTL and testbench

SHIFT_ADD_MULTIPLIER_20X20 -- requirements
Module: shift_add_multiplier_20x20

---
 rtl/shift_add_multiplier_20x20.sv | 83 ++++++++
 tb/tb_shift_add_multiplier_20x20.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier_20x20.sv
// 20x20 unsigned shift-and-add multiplier: one partial product per RUN cycle.
// Optional early termination is enabled by defining SHIFT_ADD_EARLY_TERM_EN.
module shift_add_multiplier_20x20 (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] A,
  input  logic [19:0] B,
  input  logic        start,
  output logic [39:0] Product,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [39:0] mcand;
  logic [39:0] acc;
  logic [19:0] mplier;
  logic [4:0]  count;

  logic [39:0] acc_next;
  logic [19:0] mplier_next;
  logic        last;

  // The final partial product is folded in on the same edge that leaves RUN.
  assign acc_next    = acc + (mplier[0] ? mcand : 40'd0);
  assign mplier_next = mplier >> 1;

`ifdef SHIFT_ADD_EARLY_TERM_EN
  // Once no multiplier bits remain, further cycles would only add zero.
  assign last = (count == 5'd19) || (mplier_next == 20'd0);
`else
  assign last = (count == 5'd19);
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      Product <= 40'd0;
      acc     <= 40'd0;
      mcand   <= 40'd0;
      mplier  <= 20'd0;
      count   <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {20'b0, A};
            mplier <= B;
            acc    <= 40'd0;
            count  <= 5'd0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier_next;
          count  <= count + 5'd1;
          if (last) begin
            Product <= acc_next;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier_20x20.sv
// Self-checking bench for shift_add_multiplier_20x20 against an arithmetic reference model.
// Define SHIFT_ADD_EARLY_TERM_EN to check the early-termination build.
module tb_shift_add_multiplier_20x20;

  logic        clk;
  logic        rst;
  logic [19:0] A;
  logic [19:0] B;
  logic        start;
  logic [39:0] Product;
  logic        busy;
  logic        done;

  int vectors;
  int miscompares;

  shift_add_multiplier_20x20 dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .B       (B),
    .start   (start),
    .Product (Product),
    .busy    (busy),
    .done    (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  function automatic logic [39:0] ref_product(input logic [19:0] a, input logic [19:0] b);
    logic [39:0] wa;
    logic [39:0] wb;
    wa = {20'b0, a};
    wb = {20'b0, b};
    return wa * wb;
  endfunction

  // edges from acceptance (acceptance edge counted as 1) to the edge that raises done
  function automatic int ref_latency(input logic [19:0] b);
`ifdef SHIFT_ADD_EARLY_TERM_EN
    int hi;
    hi = -1;
    for (int i = 0; i < 20; i++) if (b[i]) hi = i;
    return (hi < 0) ? 2 : hi + 2;
`else
    return 21;
`endif
  endfunction

  // driver tasks
  task automatic start_op(input logic [19:0] a, input logic [19:0] b);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 20'($urandom);
    B = 20'($urandom);
  endtask

  // Waits for done after an acceptance edge; scrambles A/B each cycle.
  task automatic wait_done(input logic [39:0] prev, output int edges,
                           output bit overlap, output bit busy_gap, output bit changed);
    edges = 1;
    overlap = 1'b0;
    busy_gap = 1'b0;
    changed = 1'b0;
    while (edges < 64) begin
      @(posedge clk);
      edges++;
      #1;
      A = 20'($urandom);
      B = 20'($urandom);
      if (busy && done) overlap = 1'b1;
      if (done) return;
      if (!busy) busy_gap = 1'b1;
      if (Product !== prev) changed = 1'b1;
    end
    edges = -1;
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    A = 20'd5;
    B = 20'd5;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags busy=%b done=%b required 0 0", busy, done);
    end
    vectors++;
    if (Product !== 40'd0) begin
      miscompares++;
      $display("FAIL reset_product got %h required 0", Product);
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_start_ignored busy=%b required 0", busy);
    end
  endtask

  task automatic test_op(input string name, input logic [19:0] a, input logic [19:0] b);
    int edges;
    bit overlap, gap, changed;
    logic [39:0] prev;
    prev = Product;
    start_op(a, b);
    wait_done(prev, edges, overlap, gap, changed);
    vectors++;
    if (edges != ref_latency(b)) begin
      miscompares++;
      $display("FAIL %s_latency got %0d required %0d", name, edges, ref_latency(b));
    end
    vectors++;
    if (Product !== ref_product(a, b)) begin
      miscompares++;
      $display("FAIL %s_product got %h required %h", name, Product, ref_product(a, b));
    end
    vectors++;
    if (overlap || gap || changed) begin
      miscompares++;
      $display("FAIL %s_flags overlap=%b busy_gap=%b early_change=%b required 0 0 0",
               name, overlap, gap, changed);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done_width done=%b busy=%b required 0 0", name, done, busy);
    end
  endtask

  task automatic test_start_held();
    int edges;
    bit overlap, gap, changed;
    A = 20'd11;
    B = 20'd13;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(Product, edges, overlap, gap, changed);
    vectors++;
    if (Product !== 40'd143 || edges != ref_latency(20'd13)) begin
      miscompares++;
      $display("FAIL held_first product %h lat %0d required %h lat %0d",
               Product, edges, 40'd143, ref_latency(20'd13));
    end
    A = 20'd21;
    B = 20'd2;
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL held_done_exit busy=%b done=%b required 0 0", busy, done);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL held_reaccept busy=%b required 1", busy);
    end
    wait_done(Product, edges, overlap, gap, changed);
    vectors++;
    if (Product !== 40'd42) begin
      miscompares++;
      $display("FAIL held_second product %h required %h", Product, 40'd42);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    start_op(20'd100, 20'hFFFFF);
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || Product !== 40'd0) begin
      miscompares++;
      $display("FAIL midrun_reset busy=%b done=%b product=%h required 0 0 0", busy, done, Product);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done || Product !== 40'd0) begin
      miscompares++;
      $display("FAIL midrun_aftermath activity=%b product=%h required 0 0", saw_done, Product);
    end
    test_op("after_reset", 20'd7, 20'd9);
  endtask

  task automatic test_back_to_back();
    logic [19:0] a, b;
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 7))
        0: a = 20'hFFFFF;
        1: a = 20'd0;
        default: a = 20'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: b = 20'hFFFFF;
        1: b = 20'($urandom_range(0, 1));
        2: b = 20'd1 << $urandom_range(0, 19);
        default: b = 20'($urandom);
      endcase
      test_op("b2b", a, b);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    start = 1'b0;
    A = 20'd0;
    B = 20'd0;
    test_reset();
    test_op("basic_3x5", 20'd3, 20'd5);
    test_op("max", 20'hFFFFF, 20'hFFFFF);
    test_op("b_one", 20'h12345, 20'd1);
    test_op("b_zero", 20'h12345, 20'd0);
    test_op("a_zero", 20'd0, 20'hABCDE);
    test_op("b_msb", 20'h00001, 20'h80000);
    test_start_held();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
